io_mux: RTL and testbench

Memory-mapped, parametrised pad multiplexer that generalises the fixed function-select muxing of the SoC top level. Each of NUM_PINS pads selects one of NUM_FUNCS peripheral functions through a per-pin register, with output-enable routing, input synchronisation, rising-edge capture and interrupt generation. It sits between the peripheral instances and the chip IO ring, on the shared core data bus alongside the GPIO, timer, PWM, I2C and SPI blocks.

---
 rtl/io_mux.sv | 184 ++++++++++++++++++
 tb/tb_io_mux.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_mux.sv
// io_mux: memory-mapped pad multiplexer with input conditioning and edge irq.
// Define IOMUX_FILTER_EN to build the per-pin input glitch filter.
module io_mux #(
    parameter logic [31:0] IOMUX_BASE_ADDR = 32'h40006000,
    parameter int NUM_PINS      = 8,
    parameter int NUM_FUNCS     = 4,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_wdata,
    input  logic                          mem_we,
    input  logic                          mem_re,
    output logic [31:0]                   mem_rdata,
    input  logic [NUM_PINS*NUM_FUNCS-1:0] func_out,
    input  logic [NUM_PINS*NUM_FUNCS-1:0] func_oe,
    output logic [NUM_PINS-1:0]           func_in,
    input  logic [NUM_PINS-1:0]           pad_in,
    output logic [NUM_PINS-1:0]           pad_out,
    output logic [NUM_PINS-1:0]           pad_oe,
    output logic                          irq
);

    localparam logic [9:0] OFF_CTRL    = 10'd0;
    localparam logic [9:0] OFF_PIN_IN  = 10'd1;
    localparam logic [9:0] OFF_EDGE    = 10'd2;
    localparam logic [9:0] OFF_EDGE_EN = 10'd3;
    localparam int         FSEL_BASE   = 64;

    logic                hit;
    logic [9:0]          offset;
    logic                wr;
    logic                rd;
    logic                lock_q;
    logic [NUM_PINS-1:0] edge_q;
    logic [NUM_PINS-1:0] edge_en_q;
    logic [4:0]          fsel_q [NUM_PINS];
    logic [NUM_PINS-1:0] sync1_q;
    logic [NUM_PINS-1:0] sync2_q;
    logic [NUM_PINS-1:0] filt;
    logic [NUM_PINS-1:0] fin_q;
    logic [NUM_PINS-1:0] inv;
    logic [NUM_PINS-1:0] edge_set;
    logic [NUM_PINS-1:0] edge_clr;
    logic [31:0]         rd_val;
    logic                unused_bits;

    assign hit    = mem_addr[31:12] == IOMUX_BASE_ADDR[31:12];
    assign offset = mem_addr[11:2];
    assign wr     = hit & mem_we;
    assign rd     = hit & mem_re;

    assign unused_bits = ^{mem_addr[1:0], mem_wdata, 8'(FILTER_CYCLES)};

    always_comb begin
        inv = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            inv[i] = fsel_q[i][4];
        end
    end

    // Out-of-range function codes leave the pad undriven.
    always_comb begin
        pad_out = '0;
        pad_oe  = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            for (int f = 0; f < NUM_FUNCS; f++) begin
                if (fsel_q[i][3:0] == 4'(f)) begin
                    pad_out[i] = func_out[i*NUM_FUNCS+f];
                    pad_oe[i]  = func_oe[i*NUM_FUNCS+f];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            fin_q   <= '0;
        end else begin
            sync1_q <= pad_in;
            sync2_q <= sync1_q;
            fin_q   <= func_in;
        end
    end

`ifdef IOMUX_FILTER_EN
    logic [NUM_PINS-1:0] filt_q;
    logic [7:0]          cnt_q [NUM_PINS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            for (int i = 0; i < NUM_PINS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PINS; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (cnt_q[i] == 8'(FILTER_CYCLES - 1)) begin
                        filt_q[i] <= ~filt_q[i];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 8'd1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync2_q;
`endif

    assign func_in  = filt ^ inv;
    assign edge_set = func_in & ~fin_q;
    assign irq      = |(edge_q & edge_en_q);

    always_comb begin
        edge_clr = '0;
        if (wr && offset == OFF_EDGE) begin
            edge_clr = mem_wdata[NUM_PINS-1:0];
        end
    end

    // A new edge in the same cycle as its W1C clear survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= 1'b0;
            edge_q    <= '0;
            edge_en_q <= '0;
            for (int i = 0; i < NUM_PINS; i++) begin
                fsel_q[i] <= '0;
            end
        end else begin
            edge_q <= (edge_q & ~edge_clr) | edge_set;
            if (wr && offset == OFF_EDGE_EN) begin
                edge_en_q <= mem_wdata[NUM_PINS-1:0];
            end
            if (wr && !lock_q) begin
                if (offset == OFF_CTRL) begin
                    lock_q <= mem_wdata[0];
                end
                for (int i = 0; i < NUM_PINS; i++) begin
                    if (offset == 10'(FSEL_BASE + i)) begin
                        fsel_q[i] <= mem_wdata[4:0];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (offset)
            OFF_CTRL:    rd_val = {31'b0, lock_q};
            OFF_PIN_IN:  rd_val = 32'(func_in);
            OFF_EDGE:    rd_val = 32'(edge_q);
            OFF_EDGE_EN: rd_val = 32'(edge_en_q);
            default: begin
                for (int i = 0; i < NUM_PINS; i++) begin
                    if (offset == 10'(FSEL_BASE + i)) begin
                        rd_val = 32'(fsel_q[i]);
                    end
                end
            end
        endcase
    end

    // Zero outside read cycles so the bus can OR-combine slaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata <= '0;
        end else begin
            mem_rdata <= rd ? rd_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_io_mux.sv
// tb_io_mux: vector table plus hand sequences for io_mux.
// Read expectations go through a scoreboard queue.
module tb_io_mux;

    localparam int NP  = 8;
    localparam int NFN = 4;
    localparam int FC  = 4;
`ifdef IOMUX_FILTER_EN
    localparam int LAT = 2 + FC;
`else
    localparam int LAT = 2;
`endif
    localparam logic [31:0] BASE = 32'h40006000;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    logic              clk;
    logic              rst;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic [NP*NFN-1:0] func_out;
    logic [NP*NFN-1:0] func_oe;
    logic [NP-1:0]     func_in;
    logic [NP-1:0]     pad_in;
    logic [NP-1:0]     pad_out;
    logic [NP-1:0]     pad_oe;
    logic              irq;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    vec_t        vecs [$];
    logic [3:0]  fsel_m [NP];

    io_mux #(
        .IOMUX_BASE_ADDR(BASE),
        .NUM_PINS(NP),
        .NUM_FUNCS(NFN),
        .FILTER_CYCLES(FC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .mem_rdata(mem_rdata),
        .func_out(func_out),
        .func_oe(func_oe),
        .func_in(func_in),
        .pad_in(pad_in),
        .pad_out(pad_out),
        .pad_oe(pad_oe),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fsel_a(input int i);
        return BASE + 32'h100 + 32'(4 * i);
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = 1'b1;
        @(negedge clk);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        chk("rdata_idle", mem_rdata, 32'd0);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] e,
                            input string name);
        mem_addr = a;
        mem_re   = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        mem_re   = 1'b0;
        mem_addr = '0;
        if (exp_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            chk(name, mem_rdata, exp_q.pop_front());
        end
    endtask

    task automatic chk_mux(input string tag);
        logic [NP-1:0] eo;
        logic [NP-1:0] ee;
        eo = '0;
        ee = '0;
        for (int i = 0; i < NP; i++) begin
            if (int'(fsel_m[i]) < NFN) begin
                eo[i] = func_out[i*NFN+int'(fsel_m[i])];
                ee[i] = func_oe[i*NFN+int'(fsel_m[i])];
            end
        end
        chk({tag, "_out"}, 32'(pad_out), 32'(eo));
        chk({tag, "_oe"}, 32'(pad_oe), 32'(ee));
    endtask

    task automatic set_fsel(input int i, input logic [3:0] f);
        bus_write(fsel_a(i), 32'(f));
        fsel_m[i] = f;
    endtask

    initial begin
        logic ok;
        rst       = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        func_out  = '0;
        func_oe   = '0;
        pad_in    = '0;
        for (int i = 0; i < NP; i++) fsel_m[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_func_in", 32'(func_in), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);

        vecs.push_back('{1'b0, BASE + 32'h000, 32'h0});
        for (int i = 0; i < NP; i++) vecs.push_back('{1'b0, fsel_a(i), 32'h0});
        vecs.push_back('{1'b0, BASE + 32'h008, 32'h0});
        vecs.push_back('{1'b0, BASE + 32'h004, 32'h0});
        vecs.push_back('{1'b1, BASE + 32'h00C, 32'hA5});
        vecs.push_back('{1'b0, BASE + 32'h00C, 32'hA5});
        vecs.push_back('{1'b1, BASE + 32'h00C, 32'hFFFFFF00});
        vecs.push_back('{1'b0, BASE + 32'h00C, 32'h0});
        vecs.push_back('{1'b1, fsel_a(1), 32'h0A});
        vecs.push_back('{1'b0, fsel_a(1), 32'h0A});
        vecs.push_back('{1'b1, fsel_a(1), 32'hFFFFFFE2});
        vecs.push_back('{1'b0, fsel_a(1), 32'h02});
        vecs.push_back('{1'b1, fsel_a(1), 32'h0});
        vecs.push_back('{1'b0, fsel_a(1), 32'h0});
        vecs.push_back('{1'b0, BASE + 32'h010, 32'h0});
        vecs.push_back('{1'b1, fsel_a(NP), 32'h5});
        vecs.push_back('{1'b0, fsel_a(NP), 32'h0});
        vecs.push_back('{1'b0, BASE + 32'hFFC, 32'h0});
        vecs.push_back('{1'b1, 32'h40007104, 32'h3});
        vecs.push_back('{1'b0, fsel_a(1), 32'h0});
        vecs.push_back('{1'b0, 32'h50006000, 32'h0});

        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].wr) bus_write(vecs[v].addr, vecs[v].data);
            else bus_read(vecs[v].addr, vecs[v].data, $sformatf("vec%0d", v));
        end

        for (int p = 0; p < 3; p++) begin
            func_out = $urandom;
            func_oe  = $urandom;
            #1;
            chk_mux($sformatf("mux_f0_%0d", p));
        end
        for (int i = 0; i < NP; i++) set_fsel(i, 4'(i % 6));
        for (int p = 0; p < 2; p++) begin
            func_out = $urandom;
            func_oe  = $urandom;
            #1;
            chk_mux($sformatf("mux_mixed_%0d", p));
        end
        for (int i = 0; i < NP; i++) set_fsel(i, 4'd0);

        func_out     = '0;
        func_oe      = '0;
        func_out[14] = 1'b1;
        func_oe[14]  = 1'b1;
        set_fsel(3, 4'h2);
        chk("fsel3_f2_out", 32'(pad_out[3]), 32'd1);
        chk("fsel3_f2_oe", 32'(pad_oe[3]), 32'd1);
        func_out = '1;
        func_oe  = '1;
        set_fsel(3, 4'hF);
        chk("fsel3_park_out", 32'(pad_out[3]), 32'd0);
        chk("fsel3_park_oe", 32'(pad_oe[3]), 32'd0);

        bus_write(BASE + 32'h00C, 32'h01);
        pad_in[0] = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        chk("pin0_early", 32'(func_in[0]), 32'd0);
        @(negedge clk);
        chk("pin0_lat", 32'(func_in[0]), 32'd1);
        chk("pin0_irq_early", 32'(irq), 32'd0);
        @(negedge clk);
        chk("pin0_irq", 32'(irq), 32'd1);
        bus_read(BASE + 32'h004, 32'h01, "pin_in");
        bus_read(BASE + 32'h008, 32'h01, "edge_pin0");
        bus_write(BASE + 32'h008, 32'h01);
        chk("irq_cleared", 32'(irq), 32'd0);
        pad_in[0] = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        bus_read(BASE + 32'h008, 32'h0, "fall_no_edge");

        bus_write(fsel_a(5), 32'h10);
        chk("inv_func_in", 32'(func_in[5]), 32'd1);
        @(negedge clk);
        chk("inv_masked_irq", 32'(irq), 32'd0);
        bus_read(BASE + 32'h008, 32'h20, "inv_edge");
        bus_write(BASE + 32'h00C, 32'h21);
        chk("inv_irq", 32'(irq), 32'd1);
        bus_write(BASE + 32'h008, 32'h20);
        chk("inv_irq_clr", 32'(irq), 32'd0);

`ifdef IOMUX_FILTER_EN
        pad_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        pad_in[1] = 1'b0;
        ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (func_in[1]) ok = 1'b0;
        end
        chk("glitch_reject", 32'(ok), 32'd1);
        pad_in[1] = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        chk("pulse6_early", 32'(func_in[1]), 32'd0);
        @(negedge clk);
        chk("pulse6_pass", 32'(func_in[1]), 32'd1);
        pad_in[1] = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        chk("pulse6_fall", 32'(func_in[1]), 32'd0);
`else
        pad_in[1] = 1'b1;
        @(negedge clk);
        pad_in[1] = 1'b0;
        @(negedge clk);
        chk("glitch_pass", 32'(func_in[1]), 32'd1);
        @(negedge clk);
        chk("glitch_end", 32'(func_in[1]), 32'd0);
        repeat (3) @(negedge clk);
        ok = 1'b1;
        chk("glitch_done", 32'(ok), 32'd1);
`endif
        bus_write(BASE + 32'h008, 32'hFF);
        bus_read(BASE + 32'h008, 32'h0, "edge_all_clr");

        pad_in[2] = 1'b1;
        repeat (LAT) @(negedge clk);
        bus_write(BASE + 32'h008, 32'h04);
        bus_read(BASE + 32'h008, 32'h04, "set_beats_clr");
        bus_write(BASE + 32'h008, 32'h04);
        bus_read(BASE + 32'h008, 32'h0, "edge2_clr");

        bus_write(BASE + 32'h000, 32'h1);
        bus_read(BASE + 32'h000, 32'h1, "lock_set");
        bus_write(fsel_a(0), 32'h1);
        bus_read(fsel_a(0), 32'h0, "lock_fsel");
        bus_write(BASE + 32'h000, 32'h0);
        bus_read(BASE + 32'h000, 32'h1, "lock_sticky");
        bus_write(BASE + 32'h00C, 32'h03);
        bus_read(BASE + 32'h00C, 32'h03, "lock_edge_en");

        mem_addr = BASE + 32'h00C;
        mem_re   = 1'b1;
        exp_q.push_back(32'h0);
        rst = 1'b1;
        #1;
        chk("async_func_in", 32'(func_in), 32'd0);
        @(negedge clk);
        mem_re   = 1'b0;
        mem_addr = '0;
        chk("rst_inflight", mem_rdata, exp_q.pop_front());
        rst = 1'b0;
        bus_read(BASE + 32'h000, 32'h0, "rst_lock");
        bus_read(BASE + 32'h00C, 32'h0, "rst_edge_en");
        bus_read(fsel_a(5), 32'h0, "rst_fsel5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
